multi_phase_driver: RTL and testbench

MULTI_PHASE_DRIVER -- requirements
Module: multi_phase_driver

---
 rtl/driver_pkg.sv | 15 +
 rtl/deadtime_gen.sv | 42 ++++
 rtl/multi_phase_driver.sv | 128 ++++++++++++
 tb/tb_multi_phase_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_pkg.sv
// driver_pkg: shared FSM states, default widths and per-channel config record for the multi-phase driver
package driver_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_RUN = 2'd2} state_t;
  localparam int DEF_CH_NUM   = 4;
  localparam int DEF_CNT_BITS = 20;
  localparam int DEF_DT_BITS  = 8;
  localparam int CFG_BITS     = 32;
  typedef struct packed {
    logic [CFG_BITS-1:0] on_time;
    logic [CFG_BITS-1:0] phase;
  } ch_cfg_t;
  function automatic logic [CFG_BITS-1:0] ch_count(input logic [CFG_BITS-1:0] cnt, per, ph);
    return (cnt >= ph) ? cnt - ph : cnt + per - ph;
  endfunction
endpackage

// File: rtl/deadtime_gen.sv
// deadtime_gen: turns one raw PWM level into complementary hi/lo drives with rising-edge dead time
module deadtime_gen import driver_pkg::*; #(
  parameter int DT_BITS = DEF_DT_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_raw,
  input  logic [DT_BITS-1:0] i_dt,
  input  logic               i_en,
  output logic               o_hi,
  output logic               o_lo
);
  logic             r_prev;
  logic [DT_BITS:0] r_len;
  logic [DT_BITS:0] w_len;
  logic             w_settled;
  // length of the current run of equal raw levels, saturating once it exceeds the dead time
  always_comb begin
    w_len     = (i_raw != r_prev) ? (DT_BITS+1)'(1) :
                (r_len > {1'b0, i_dt}) ? r_len : r_len + (DT_BITS+1)'(1);
    w_settled = w_len > {1'b0, i_dt};
  end
  // a side turns on only after raw has held its level for dt+1 cycles; turning off is immediate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_len  <= '0;
      o_hi   <= 1'b0;
      o_lo   <= 1'b0;
    end else if (!i_en) begin
      r_prev <= i_raw;
      r_len  <= '0;
      o_hi   <= 1'b0;
      o_lo   <= 1'b0;
    end else begin
      r_prev <= i_raw;
      r_len  <= w_len;
      o_hi   <= i_raw && w_settled;
      o_lo   <= !i_raw && w_settled;
    end
  end
endmodule

// File: rtl/multi_phase_driver.sv
// multi_phase_driver: phase-shifted multi-channel PWM with shadowed config and dead time; DRIVER_FAULT_EN adds a latching fault input
module multi_phase_driver import driver_pkg::*; #(
  parameter int CH_NUM   = DEF_CH_NUM,
  parameter int CNT_BITS = DEF_CNT_BITS,
  parameter int DT_BITS  = DEF_DT_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  input  logic [CNT_BITS-1:0]        period,
  input  logic [CH_NUM*CNT_BITS-1:0] on_time,
  input  logic [CH_NUM*CNT_BITS-1:0] phase,
  input  logic [DT_BITS-1:0]         deadtime,
  input  logic [CH_NUM-1:0]          ch_en,
  output logic [CH_NUM-1:0]          hi,
  output logic [CH_NUM-1:0]          lo,
  output logic                       sync,
  output logic                       upd_done
`ifdef DRIVER_FAULT_EN
  ,input logic                       fault
`endif
);
  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt, r_per_sh, r_per_act;
  logic [DT_BITS-1:0]  r_dt_sh, r_dt_act;
  ch_cfg_t             r_sh [CH_NUM];
  ch_cfg_t             r_act [CH_NUM];
  logic [CH_NUM-1:0]   r_raw, w_hi, w_lo, w_bad_ph;
  logic                r_sync0, r_sync, r_upd, r_err;
  logic                w_try, w_bad, w_acc, w_live, w_wrap, w_load, w_kill;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ph
    assign w_bad_ph[g] = phase[g*CNT_BITS +: CNT_BITS] >= period;
  end

  assign cfg_ready = r_state != S_PEND;
  assign w_try     = cfg_valid && cfg_ready;
  assign w_bad     = period < CNT_BITS'(2) || |w_bad_ph;
  assign w_acc     = w_try && !w_bad;
  // an all-zero active period means nothing has gone live since reset
  assign w_live    = r_per_act != '0;
  assign w_wrap    = r_cnt == r_per_act - CNT_BITS'(1);
  assign w_load    = r_state == S_PEND && (!w_live || w_wrap);

  // control FSM, shadow/active config registers and the master counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_per_sh  <= '0;
      r_per_act <= '0;
      r_dt_sh   <= '0;
      r_dt_act  <= '0;
      r_err     <= 1'b0;
      r_upd     <= 1'b0;
      r_sync0   <= 1'b0;
      r_sync    <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_sh[i]  <= '0;
        r_act[i] <= '0;
      end
    end else begin
      r_err   <= w_try && w_bad;
      r_upd   <= w_load;
      r_sync0 <= w_live && r_cnt == '0;
      r_sync  <= r_sync0;
      r_cnt   <= (!w_live || w_wrap) ? '0 : r_cnt + CNT_BITS'(1);
      r_state <= w_acc ? S_PEND : w_load ? S_RUN : r_state;
      if (w_acc) begin
        r_per_sh <= period;
        r_dt_sh  <= deadtime;
        for (int i = 0; i < CH_NUM; i++)
          r_sh[i] <= '{on_time: CFG_BITS'(on_time[i*CNT_BITS +: CNT_BITS]),
                       phase:   CFG_BITS'(phase[i*CNT_BITS +: CNT_BITS])};
      end
      if (w_load) begin
        r_per_act <= r_per_sh;
        r_dt_act  <= r_dt_sh;
        for (int i = 0; i < CH_NUM; i++)
          r_act[i] <= r_sh[i];
      end
    end
  end

  // raw per-channel level: phase-shifted count compared against on-time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_raw <= '0;
    else
      for (int i = 0; i < CH_NUM; i++)
        r_raw[i] <= w_live &&
                    ch_count(CFG_BITS'(r_cnt), CFG_BITS'(r_per_act), r_act[i].phase) < r_act[i].on_time;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    deadtime_gen #(.DT_BITS(DT_BITS)) u_dt (
      .clk  (clk),
      .rst_n(rst_n),
      .i_raw(r_raw[g]),
      .i_dt (r_dt_act),
      .i_en (ch_en[g] && r_state != S_IDLE),
      .o_hi (w_hi[g]),
      .o_lo (w_lo[g])
    );
  end

`ifdef DRIVER_FAULT_EN
  logic r_fault;
  // fault latches until a configuration is accepted; a live fault input still wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fault <= 1'b0;
    else
      r_fault <= fault || (r_fault && !w_acc);
  end
  assign w_kill = fault || r_fault;
`else
  assign w_kill = 1'b0;
`endif

  assign hi       = w_hi & ~{CH_NUM{w_kill}};
  assign lo       = w_lo & ~{CH_NUM{w_kill}};
  assign sync     = r_sync;
  assign upd_done = r_upd;
  assign cfg_err  = r_err;
endmodule

// File: tb/tb_multi_phase_driver.sv
// tb_multi_phase_driver: directed checks of phasing, dead time, config handshake, reset and fault
module tb_multi_phase_driver;
  logic        clk = 1'b0;
  logic        rst_n, cfg_valid, cfg_ready, cfg_err, sync, upd_done;
  logic [19:0] period;
  logic [79:0] on_time, phase;
  logic [7:0]  deadtime;
  logic [3:0]  ch_en, hi, lo;
`ifdef DRIVER_FAULT_EN
  logic        fault = 1'b0;
`endif
  int          checks = 0, errors = 0;
  logic [9:0]  cap_hi [4];
  logic [9:0]  cap_lo [4];
  logic [9:0]  cap_sync;
  logic [9:0]  e_hi [4];
  logic [9:0]  e_lo [4];

  multi_phase_driver dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .period(period), .on_time(on_time), .phase(phase), .deadtime(deadtime), .ch_en(ch_en),
    .hi(hi), .lo(lo), .sync(sync), .upd_done(upd_done)
`ifdef DRIVER_FAULT_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [19:0] p, input logic [79:0] o, ph, input logic [7:0] dt);
    period = p; on_time = o; phase = ph; deadtime = dt;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_sync();
    int n = 0;
    do begin step(); n++; end while (sync !== 1'b1 && n < 100);
    if (sync !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_sync timeout got %b want 1", sync);
    end
  endtask

  task automatic count_to_sync(output int n);
    n = 0;
    do begin step(); n++; end while (sync !== 1'b1 && n < 100);
  endtask

  task automatic wait_upd(output int n);
    n = 0;
    while (upd_done !== 1'b1 && n < 100) begin step(); n++; end
    if (upd_done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_upd timeout got %b want 1", upd_done);
    end
  endtask

  task automatic capture();
    wait_sync();
    wait_sync();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) begin
        cap_hi[i][k] = hi[i];
        cap_lo[i][k] = lo[i];
      end
      cap_sync[k] = sync;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; ch_en = 4'hF;
    period = '0; on_time = '0; phase = '0; deadtime = '0;
    repeat (3) step();
    checks++; if ({hi, lo} !== 8'h00) begin errors++; $display("FAIL reset_hold hilo got %h want 00", {hi, lo}); end
    rst_n = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready got %b want 1", cfg_ready); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset sync got %b want 0", sync); end
    checks++; if (upd_done !== 1'b0) begin errors++; $display("FAIL reset upd_done got %b want 0", upd_done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset cfg_err got %b want 0", cfg_err); end
    checks++; if ({hi, lo} !== 8'h00) begin errors++; $display("FAIL reset hilo got %h want 00", {hi, lo}); end
  endtask

  task automatic test_phases();
    apply(20'd10, {20'd5, 20'd5, 20'd5, 20'd5}, {20'd7, 20'd5, 20'd2, 20'd0}, 8'd0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL phases pend_ready got %b want 0", cfg_ready); end
    step();
    checks++; if (upd_done !== 1'b1) begin errors++; $display("FAIL phases upd_done got %b want 1", upd_done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL phases run_ready got %b want 1", cfg_ready); end
    capture();
    e_hi = '{10'h01F, 10'h07C, 10'h3E0, 10'h383};
    e_lo = '{10'h3E0, 10'h383, 10'h01F, 10'h07C};
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_hi[i] !== e_hi[i]) begin errors++; $display("FAIL phases hi[%0d] got %h want %h", i, cap_hi[i], e_hi[i]); end
      checks++; if (cap_lo[i] !== e_lo[i]) begin errors++; $display("FAIL phases lo[%0d] got %h want %h", i, cap_lo[i], e_lo[i]); end
    end
    checks++; if (cap_sync !== 10'h001) begin errors++; $display("FAIL phases sync got %h want 001", cap_sync); end
  endtask

  task automatic test_deadtime();
    int n;
    apply(20'd10, {20'd5, 20'd5, 20'd5, 20'd5}, {20'd7, 20'd5, 20'd2, 20'd0}, 8'd2);
    wait_upd(n);
    capture();
    e_hi = '{10'h01C, 10'h070, 10'h380, 10'h203};
    e_lo = '{10'h380, 10'h203, 10'h01C, 10'h070};
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_hi[i] !== e_hi[i]) begin errors++; $display("FAIL deadtime hi[%0d] got %h want %h", i, cap_hi[i], e_hi[i]); end
      checks++; if (cap_lo[i] !== e_lo[i]) begin errors++; $display("FAIL deadtime lo[%0d] got %h want %h", i, cap_lo[i], e_lo[i]); end
    end
  endtask

  task automatic test_suppress();
    int n;
    apply(20'd10, {20'd5, 20'd5, 20'd5, 20'd5}, {20'd7, 20'd5, 20'd2, 20'd0}, 8'd5);
    wait_upd(n);
    capture();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({cap_hi[i], cap_lo[i]} !== 20'h0) begin errors++; $display("FAIL suppress ch%0d got %h/%h want 000/000", i, cap_hi[i], cap_lo[i]); end
    end
  endtask

  task automatic test_ontime();
    int n;
    ch_en = 4'b1011;
    apply(20'd10, {20'd5, 20'd5, 20'd15, 20'd0}, '0, 8'd0);
    wait_upd(n);
    capture();
    e_hi = '{10'h000, 10'h3FF, 10'h000, 10'h01F};
    e_lo = '{10'h3FF, 10'h000, 10'h000, 10'h3E0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_hi[i] !== e_hi[i]) begin errors++; $display("FAIL ontime hi[%0d] got %h want %h", i, cap_hi[i], e_hi[i]); end
      checks++; if (cap_lo[i] !== e_lo[i]) begin errors++; $display("FAIL ontime lo[%0d] got %h want %h", i, cap_lo[i], e_lo[i]); end
    end
  endtask

  task automatic test_reject();
    apply(20'd10, {20'd5, 20'd5, 20'd5, 20'd5}, {20'd0, 20'd0, 20'd0, 20'd12}, 8'd0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject_phase cfg_err got %b want 1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reject_phase cfg_ready got %b want 1", cfg_ready); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reject_pulse cfg_err got %b want 0", cfg_err); end
    capture();
    checks++; if (cap_hi[1] !== 10'h3FF) begin errors++; $display("FAIL reject_keep hi[1] got %h want 3ff", cap_hi[1]); end
    checks++; if (cap_hi[3] !== 10'h01F) begin errors++; $display("FAIL reject_keep hi[3] got %h want 01f", cap_hi[3]); end
    apply(20'd1, '0, '0, 8'd0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject_period cfg_err got %b want 1", cfg_err); end
  endtask

  task automatic test_reset_mid();
    logic bad = 1'b0;
    checks++; if (hi[1] !== 1'b1) begin errors++; $display("FAIL reset_mid pre hi[1] got %b want 1", hi[1]); end
    rst_n = 1'b0;
    #1;
    checks++; if ({hi, lo} !== 8'h00) begin errors++; $display("FAIL reset_mid hilo got %h want 00", {hi, lo}); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_mid cfg_ready got %b want 1", cfg_ready); end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      bad |= sync | upd_done | (|hi) | (|lo);
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_idle activity got %b want 0", bad); end
  endtask

  task automatic test_update();
    int n;
    ch_en = 4'hF;
    apply(20'd10, {20'd5, 20'd5, 20'd5, 20'd5}, '0, 8'd0);
    wait_upd(n);
    wait_sync();
    step();
    period = 20'd10 * 2; on_time = {20'd10, 20'd10, 20'd10, 20'd10}; phase = '0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL update pend_ready got %b want 0", cfg_ready); end
    wait_upd(n);
    checks++; if (n != 6) begin errors++; $display("FAIL update load_delay got %0d want 6", n); end
    step();
    checks++; if (upd_done !== 1'b0) begin errors++; $display("FAIL update upd_pulse got %b want 0", upd_done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL update run_ready got %b want 1", cfg_ready); end
    count_to_sync(n);
    checks++; if (n != 1) begin errors++; $display("FAIL update first_sync got %0d want 1", n); end
    count_to_sync(n);
    checks++; if (n != 20) begin errors++; $display("FAIL update new_period got %0d want 20", n); end
  endtask

  task automatic test_wrap_accept();
    int n;
    repeat (17) step();
    period = 20'd10; on_time = {20'd5, 20'd5, 20'd5, 20'd5}; phase = '0;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL wrap pend_ready got %b want 0", cfg_ready); end
    wait_upd(n);
    checks++; if (n != 20) begin errors++; $display("FAIL wrap load_delay got %0d want 20", n); end
    step();
    count_to_sync(n);
    checks++; if (n != 1) begin errors++; $display("FAIL wrap first_sync got %0d want 1", n); end
    count_to_sync(n);
    checks++; if (n != 10) begin errors++; $display("FAIL wrap new_period got %0d want 10", n); end
  endtask

`ifdef DRIVER_FAULT_EN
  task automatic test_fault();
    int n;
    apply(20'd10, {20'd5, 20'd15, 20'd5, 20'd5}, '0, 8'd0);
    wait_upd(n);
    wait_sync();
    wait_sync();
    checks++; if (hi[2] !== 1'b1) begin errors++; $display("FAIL fault pre hi[2] got %b want 1", hi[2]); end
    fault = 1'b1;
    #1;
    checks++; if ({hi, lo} !== 8'h00) begin errors++; $display("FAIL fault comb hilo got %h want 00", {hi, lo}); end
    step();
    fault = 1'b0;
    repeat (12) step();
    checks++; if ({hi, lo} !== 8'h00) begin errors++; $display("FAIL fault latch hilo got %h want 00", {hi, lo}); end
    apply(20'd10, {20'd5, 20'd15, 20'd5, 20'd5}, '0, 8'd0);
    wait_upd(n);
    wait_sync();
    wait_sync();
    checks++; if (hi[2] !== 1'b1) begin errors++; $display("FAIL fault clear hi[2] got %b want 1", hi[2]); end
  endtask
`endif

  initial begin
    test_reset();
    test_phases();
    test_deadtime();
    test_suppress();
    test_ontime();
    test_reject();
    test_reset_mid();
    test_update();
    test_wrap_accept();
`ifdef DRIVER_FAULT_EN
    test_fault();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
